// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder and
// the execute-stage FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_ADDU  = 4'b0100;
    localparam logic [3:0] ALU_SUBU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_BREAK = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the issue logic and the execute-stage ALU.
interface alu_exec_if #(parameter int WIDTH = 32);

    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             done;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             brk;

    modport master (
        output start, control, a, b,
        input  result, zero, overflow, done, busy, hi, lo, brk
    );

    modport slave (
        input  start, control, a, b,
        output result, zero, overflow, done, busy, hi, lo, brk
    );

endinterface

// File: rtl/alu_exec_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step,
// WIDTH steps per product. Sign handling is done by the caller.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] product_next,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;

    // Accumulator value after the current step; exposed so the caller can
    // capture the finished product on the same edge as the final step.
    always_comb begin
        product_next = acc_r;
        if (mplier_r[0]) begin
            product_next = acc_r + mcand_r;
        end else begin
            product_next = acc_r;
        end
        last = (cnt_r == CW'(WIDTH - 1));
    end

    // Load operands, then add-and-shift once per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (load) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, mcand};
            mplier_r <= mplier;
            cnt_r    <= {CW{1'b0}};
        end else if (step) begin
            acc_r    <= product_next;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops with registered
// result and done pulse, plus a sequential MULT/MULTU writing HI/LO.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_exec_if.slave bus
);

    alu_state_e         state_r, next_state_s;
    logic [WIDTH-1:0]   result_r, result_d_s, hi_r, hi_d_s, lo_r, lo_d_s;
    logic               zero_r, zero_d_s, ovf_r, ovf_d_s, done_r, done_d_s;
    logic               busy_r, brk_r, brk_d_s, neg_r;
    logic [WIDTH-1:0]   alu_res_s, mcand_in_s, mplier_in_s, sum_s, diff_s;
    logic               alu_ovf_s, accept_s, is_mul_s, is_signed_mul_s;
    logic               mul_load_s, mul_step_s, mul_last_s;
    logic [2*WIDTH-1:0] prod_raw_s, prod_s;

    assign accept_s        = bus.start && (state_r == ST_IDLE);
    assign is_mul_s        = (bus.control == ALU_MULT) || (bus.control == ALU_MULTU);
    assign is_signed_mul_s = (bus.control == ALU_MULT);
    assign sum_s           = bus.a + bus.b;
    assign diff_s          = bus.a - bus.b;
    // Two's-complement negation of the most-negative value yields 2^(WIDTH-1), correct as unsigned.
    assign mcand_in_s  = (is_signed_mul_s && bus.a[WIDTH-1]) ? (~bus.a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;
    assign mplier_in_s = (is_signed_mul_s && bus.b[WIDTH-1]) ? (~bus.b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.b;
    assign prod_s      = neg_r ? (~prod_raw_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_raw_s;

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .load         (mul_load_s),
        .step         (mul_step_s),
        .mcand        (mcand_in_s),
        .mplier       (mplier_in_s),
        .product_next (prod_raw_s),
        .last         (mul_last_s)
    );

    // Single-cycle operation datapath.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (bus.control)
            ALU_AND:  alu_res_s = bus.a & bus.b;
            ALU_OR:   alu_res_s = bus.a | bus.b;
            ALU_XOR:  alu_res_s = bus.a ^ bus.b;
            ALU_ADDU: alu_res_s = sum_s;
            ALU_SUBU: alu_res_s = diff_s;
            ALU_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            ALU_LUI:  alu_res_s = {bus.b[15:0], {(WIDTH-16){1'b0}}};
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    next_state_s = ST_MUL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output/next-register logic; registered values hold unless an op completes.
    always_comb begin
        result_d_s = result_r;
        zero_d_s   = zero_r;
        ovf_d_s    = ovf_r;
        hi_d_s     = hi_r;
        lo_d_s     = lo_r;
        brk_d_s    = brk_r;
        done_d_s   = 1'b0;
        mul_load_s = 1'b0;
        mul_step_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    mul_load_s = 1'b1;
                end else if (accept_s) begin
                    result_d_s = alu_res_s;
                    zero_d_s   = (alu_res_s == {WIDTH{1'b0}});
                    ovf_d_s    = alu_ovf_s;
                    done_d_s   = 1'b1;
                    brk_d_s    = brk_r | (bus.control == ALU_BREAK);
                end else begin
                    done_d_s   = 1'b0;
                end
            end
            ST_MUL: begin
                mul_step_s = 1'b1;
                if (mul_last_s) begin
                    {hi_d_s, lo_d_s} = prod_s;
                    result_d_s = prod_s[WIDTH-1:0];
                    zero_d_s   = (prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    ovf_d_s    = 1'b0;
                    done_d_s   = 1'b1;
                end else begin
                    done_d_s   = 1'b0;
                end
            end
            default: begin
                done_d_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            brk_r    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            result_r <= result_d_s;
            zero_r   <= zero_d_s;
            ovf_r    <= ovf_d_s;
            done_r   <= done_d_s;
            busy_r   <= (next_state_s == ST_MUL);
            hi_r     <= hi_d_s;
            lo_r     <= lo_d_s;
            brk_r    <= brk_d_s;
            neg_r    <= mul_load_s ? (is_signed_mul_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])) : neg_r;
        end
    end

    assign bus.result   = result_r;
    assign bus.zero     = zero_r;
    assign bus.overflow = ovf_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.brk      = brk_r;

endmodule
